rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 143 ++++++++++++++
 tb/tb_rom_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port (fetch/load) arbiter in front of a combinational ROM
//
// Purpose: accepts one read request per cycle from the fetch or load port,
// registers the ROM word index, and returns the ROM word one cycle later.
// Fetch has priority; a starvation counter forces a load grant after
// STARVE_LIMIT consecutive load denials. Build macro ROM_ARB_RR_EN replaces
// this with round-robin arbitration (no starvation counter).
//
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_if_req/i_if_addr/o_if_ack         fetch request, byte address, accept
//   o_if_valid/o_if_data                fetch response pulse and data
//   i_ld_req/i_ld_addr/o_ld_ack         load request, byte address, accept
//   o_ld_valid/o_ld_data                load response pulse and data
//   o_rom_addr/i_rom_data               registered word index / ROM data
//   o_err                               response was misaligned or out of range
module rom_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ROM_WORDS    = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_ack,
    output logic                  o_if_valid,
    output logic [DATA_WIDTH-1:0] o_if_data,
    input  logic                  i_ld_req,
    input  logic [ADDR_WIDTH-1:0] i_ld_addr,
    output logic                  o_ld_ack,
    output logic                  o_ld_valid,
    output logic [DATA_WIDTH-1:0] o_ld_data,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    output logic                  o_err
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LD} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] if_data_q, ld_data_q;

    logic                  pick_ld;
    logic                  grant_if, grant_ld;
    logic [ADDR_WIDTH-1:0] sel_addr, sel_word;
    logic                  sel_bad;

`ifdef ROM_ARB_RR_EN
    // Remembers which port won last; it loses the next contested cycle.
    // Resets to "load last" so fetch wins the first contest.
    logic last_ld_q, last_ld_d;

    assign pick_ld   = i_ld_req && (!i_if_req || !last_ld_q);
    assign last_ld_d = grant_ld ? 1'b1 : (grant_if ? 1'b0 : last_ld_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) last_ld_q <= 1'b1;
        else          last_ld_q <= last_ld_d;
    end
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          starve_hit;

    assign starve_hit = (starve_q == CW'(STARVE_LIMIT));
    assign pick_ld    = i_ld_req && (!i_if_req || starve_hit);

    // Counts consecutive cycles a held load request was denied.
    always_comb begin
        starve_d = starve_q;
        if (!i_ld_req || grant_ld) starve_d = '0;
        else if (!starve_hit)      starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`endif

    // Acks are gated by reset so nothing is accepted while held in reset.
    assign grant_ld = i_rst_n && pick_ld;
    assign grant_if = i_rst_n && i_if_req && !pick_ld;
    assign o_if_ack = grant_if;
    assign o_ld_ack = grant_ld;

    assign sel_addr = grant_ld ? i_ld_addr : i_if_addr;
    assign sel_word = sel_addr >> 2;
    assign sel_bad  = (sel_addr[1:0] != 2'b00) || (sel_word >= ADDR_WIDTH'(ROM_WORDS));

    always_comb begin
        state_d    = IDLE;
        rom_addr_d = rom_addr_q;
        err_d      = 1'b0;
        if (grant_if) begin
            state_d    = BUSY_IF;
            rom_addr_d = sel_word;
            err_d      = sel_bad;
        end else if (grant_ld) begin
            state_d    = BUSY_LD;
            rom_addr_d = sel_word;
            err_d      = sel_bad;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            err_q      <= err_d;
        end
    end

    // The response cycle is the BUSY state itself: ROM data is presented
    // combinationally during the valid pulse and captured into the hold
    // register at its closing edge, so the output keeps its last value.
    assign o_if_valid = (state_q == BUSY_IF);
    assign o_ld_valid = (state_q == BUSY_LD);
    assign o_if_data  = o_if_valid ? (err_q ? '0 : i_rom_data) : if_data_q;
    assign o_ld_data  = o_ld_valid ? (err_q ? '0 : i_rom_data) : ld_data_q;
    assign o_rom_addr = rom_addr_q;
    assign o_err      = err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            if_data_q <= '0;
            ld_data_q <= '0;
        end else begin
            if (o_if_valid) if_data_q <= o_if_data;
            if (o_ld_valid) ld_data_q <= o_ld_data;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, ld_req;
    logic [31:0] if_addr, ld_addr;
    logic        if_ack, ld_ack, if_valid, ld_valid, err;
    logic [31:0] if_data, ld_data, rom_addr, rom_data;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] w);
        return (w * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    rom_arbiter dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_if_req   (if_req),
        .i_if_addr  (if_addr),
        .o_if_ack   (if_ack),
        .o_if_valid (if_valid),
        .o_if_data  (if_data),
        .i_ld_req   (ld_req),
        .i_ld_addr  (ld_addr),
        .o_ld_ack   (ld_ack),
        .o_ld_valid (ld_valid),
        .o_ld_data  (ld_data),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_err      (err)
    );

    task automatic test_reset;
        rst_n = 1'b0; if_req = 1'b1; ld_req = 1'b1; if_addr = 32'h8; ld_addr = 32'h8;
        @(negedge clk); #1;
        tests_run++; if (if_ack !== 1'b0 || ld_ack !== 1'b0) begin tests_failed++;
            $display("FAIL reset_acks if_ack=%b ld_ack=%b expected 0 0", if_ack, ld_ack); end
        tests_run++; if (if_valid !== 1'b0 || ld_valid !== 1'b0 || err !== 1'b0) begin tests_failed++;
            $display("FAIL reset_pulses if_valid=%b ld_valid=%b err=%b expected 0", if_valid, ld_valid, err); end
        tests_run++; if (rom_addr !== 32'h0 || if_data !== 32'h0 || ld_data !== 32'h0) begin tests_failed++;
            $display("FAIL reset_regs rom_addr=%h if_data=%h ld_data=%h expected 0", rom_addr, if_data, ld_data); end
        if_req = 1'b0; ld_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_fetch;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h8; #1;
        tests_run++; if (if_ack !== 1'b1 || ld_ack !== 1'b0) begin tests_failed++;
            $display("FAIL fetch_ack if_ack=%b ld_ack=%b expected 1 0", if_ack, ld_ack); end
        @(negedge clk); if_req = 1'b0; #1;
        tests_run++; if (if_valid !== 1'b1 || rom_addr !== 32'd2) begin tests_failed++;
            $display("FAIL fetch_valid if_valid=%b rom_addr=%0d expected 1 2", if_valid, rom_addr); end
        tests_run++; if (if_data !== rom_fn(32'd2) || err !== 1'b0) begin tests_failed++;
            $display("FAIL fetch_data if_data=%h err=%b expected %h 0", if_data, err, rom_fn(32'd2)); end
        @(negedge clk); #1;
        tests_run++; if (if_valid !== 1'b0 || if_data !== rom_fn(32'd2)) begin tests_failed++;
            $display("FAIL fetch_hold if_valid=%b if_data=%h expected 0 %h", if_valid, if_data, rom_fn(32'd2)); end
    endtask

`ifndef ROM_ARB_RR_EN
    task automatic test_starve;
        logic prev_ld, prev_if, exp_ld;
        prev_ld = 1'b0; prev_if = 1'b0;
        for (int c = 0; c < 10; c++) begin
            exp_ld = (c == 4) || (c == 9);
            @(negedge clk); if_req = 1'b1; ld_req = 1'b1; if_addr = 32'h10; ld_addr = 32'h20; #1;
            tests_run++; if (if_ack !== !exp_ld || ld_ack !== exp_ld) begin tests_failed++;
                $display("FAIL starve_ack c=%0d if_ack=%b ld_ack=%b expected %b %b", c, if_ack, ld_ack, !exp_ld, exp_ld); end
            tests_run++; if (ld_valid !== prev_ld || if_valid !== prev_if) begin tests_failed++;
                $display("FAIL starve_valid c=%0d if_valid=%b ld_valid=%b expected %b %b", c, if_valid, ld_valid, prev_if, prev_ld); end
            if (prev_if) begin
                tests_run++; if (if_data !== rom_fn(32'd4)) begin tests_failed++;
                    $display("FAIL starve_if_data c=%0d got %h expected %h", c, if_data, rom_fn(32'd4)); end
            end
            prev_ld = exp_ld; prev_if = !exp_ld;
        end
        @(negedge clk); if_req = 1'b0; ld_req = 1'b0; #1;
        tests_run++; if (ld_valid !== 1'b1 || ld_data !== rom_fn(32'd8)) begin tests_failed++;
            $display("FAIL starve_ld_data ld_valid=%b ld_data=%h expected 1 %h", ld_valid, ld_data, rom_fn(32'd8)); end
    endtask

    task automatic test_drop;
        logic [7:0] ld_pat, exp_pat;
        ld_pat  = 8'b1111_1011;
        exp_pat = 8'b1000_0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); if_req = 1'b1; ld_req = ld_pat[c]; if_addr = 32'h10; ld_addr = 32'h20; #1;
            tests_run++; if (ld_ack !== exp_pat[c] || if_ack !== !exp_pat[c]) begin tests_failed++;
                $display("FAIL drop_ack c=%0d if_ack=%b ld_ack=%b expected %b %b", c, if_ack, ld_ack, !exp_pat[c], exp_pat[c]); end
        end
        @(negedge clk); if_req = 1'b0; ld_req = 1'b0;
        @(negedge clk);
    endtask
`else
    task automatic test_rr;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); if_req = 1'b1; ld_req = 1'b1; if_addr = 32'h10; ld_addr = 32'h20; #1;
            tests_run++; if (ld_ack !== c[0] || if_ack !== !c[0]) begin tests_failed++;
                $display("FAIL rr_ack c=%0d if_ack=%b ld_ack=%b expected %b %b", c, if_ack, ld_ack, !c[0], c[0]); end
        end
        @(negedge clk); if_req = 1'b0; ld_req = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_err;
        @(negedge clk); ld_req = 1'b1; ld_addr = 32'h6; #1;
        tests_run++; if (ld_ack !== 1'b1) begin tests_failed++;
            $display("FAIL err_ack_misaligned ld_ack=%b expected 1", ld_ack); end
        @(negedge clk); ld_addr = 32'h1000; #1;
        tests_run++; if (ld_ack !== 1'b1) begin tests_failed++;
            $display("FAIL err_ack_range ld_ack=%b expected 1", ld_ack); end
        tests_run++; if (ld_valid !== 1'b1 || ld_data !== 32'h0 || err !== 1'b1) begin tests_failed++;
            $display("FAIL err_misaligned valid=%b data=%h err=%b expected 1 0 1", ld_valid, ld_data, err); end
        @(negedge clk); ld_addr = 32'hFFC; #1;
        tests_run++; if (ld_valid !== 1'b1 || ld_data !== 32'h0 || err !== 1'b1) begin tests_failed++;
            $display("FAIL err_range valid=%b data=%h err=%b expected 1 0 1", ld_valid, ld_data, err); end
        @(negedge clk); ld_req = 1'b0; #1;
        tests_run++; if (ld_valid !== 1'b1 || ld_data !== rom_fn(32'd1023) || err !== 1'b0) begin tests_failed++;
            $display("FAIL err_last_word valid=%b data=%h err=%b expected 1 %h 0", ld_valid, ld_data, err, rom_fn(32'd1023)); end
        @(negedge clk); #1;
        tests_run++; if (ld_valid !== 1'b0 || err !== 1'b0 || ld_data !== rom_fn(32'd1023)) begin tests_failed++;
            $display("FAIL err_hold valid=%b err=%b data=%h expected 0 0 %h", ld_valid, err, ld_data, rom_fn(32'd1023)); end
    endtask

    task automatic test_reset_busy;
        @(negedge clk); if_req = 1'b1; if_addr = 32'hC; #1;
        tests_run++; if (if_ack !== 1'b1) begin tests_failed++;
            $display("FAIL rbusy_ack if_ack=%b expected 1", if_ack); end
        @(posedge clk); #2; if_req = 1'b0; rst_n = 1'b0; #1;
        tests_run++; if (if_valid !== 1'b0 || ld_valid !== 1'b0 || err !== 1'b0) begin tests_failed++;
            $display("FAIL rbusy_pulses if_valid=%b ld_valid=%b err=%b expected 0", if_valid, ld_valid, err); end
        tests_run++; if (rom_addr !== 32'h0 || if_data !== 32'h0 || ld_data !== 32'h0) begin tests_failed++;
            $display("FAIL rbusy_regs rom_addr=%h if_data=%h ld_data=%h expected 0", rom_addr, if_data, ld_data); end
        @(negedge clk); #1;
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++;
            $display("FAIL rbusy_discard if_valid=%b expected 0", if_valid); end
        rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h14; #1;
        tests_run++; if (if_ack !== 1'b1) begin tests_failed++;
            $display("FAIL rbusy_reack if_ack=%b expected 1", if_ack); end
        @(negedge clk); if_req = 1'b0; #1;
        tests_run++; if (if_valid !== 1'b1 || rom_addr !== 32'd5 || if_data !== rom_fn(32'd5)) begin tests_failed++;
            $display("FAIL rbusy_resp valid=%b rom_addr=%0d data=%h expected 1 5 %h", if_valid, rom_addr, if_data, rom_fn(32'd5)); end
    endtask

    initial begin
        if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_addr = '0;
        test_reset;
        test_fetch;
`ifndef ROM_ARB_RR_EN
        test_starve;
        test_drop;
`else
        test_rr;
`endif
        test_err;
        test_reset_busy;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
